// File: rtl/soc_interconnect.sv
// Multi-master, multi-slave shared bus: round-robin arbiter, mask/base decoder,
// slave ready handshake with optional timeout, and a saturating error counter.
module soc_interconnect #(
   parameter int                      NM        = 2,
   parameter int                      NS        = 4,
   parameter int                      ADDR_W    = 8,
   parameter int                      DATA_W    = 8,
   parameter logic [NS*ADDR_W-1:0]    SLV_BASE  = {8'hA0, 8'h90, 8'h80, 8'h00},
   parameter logic [NS*ADDR_W-1:0]    SLV_MASK  = {8'hF0, 8'hF0, 8'hF0, 8'h80},
   parameter int                      TIMEOUT   = 16,
   parameter logic [DATA_W-1:0]       ERR_RDATA = '1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NM-1:0]          m_valid,
   input  logic [NM-1:0]          m_we,
   input  logic [NM*ADDR_W-1:0]   m_addr,
   input  logic [NM*DATA_W-1:0]   m_wdata,
   output logic [NM*DATA_W-1:0]   m_rdata,
   output logic [NM-1:0]          m_ready,
   output logic [NM-1:0]          m_err,
   output logic [NS-1:0]          s_cs,
   output logic                   s_we,
   output logic [ADDR_W-1:0]      s_addr,
   output logic [DATA_W-1:0]      s_wdata,
   input  logic [NS*DATA_W-1:0]   s_rdata,
   input  logic [NS-1:0]          s_ready,
   output logic [NM-1:0]          grant,
   output logic [7:0]             err_count
);

   localparam int MW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t              state_q, state_d;
   logic [MW-1:0]       ptr_q, ptr_d;
   logic [MW-1:0]       gidx_q, gidx_d;
   logic [SW-1:0]       slv_q, slv_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NM-1:0]       grant_q, grant_d;
   logic [NS-1:0]       s_cs_q, s_cs_d;
   logic                s_we_q, s_we_d;
   logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
   logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
   logic [NM-1:0]       m_ready_q, m_ready_d;
   logic [NM-1:0]       m_err_q, m_err_d;
   logic [NM*DATA_W-1:0] m_rdata_q, m_rdata_d;
   logic [7:0]          err_count_q, err_count_d;

   logic                req_found;
   logic [MW-1:0]       req_idx;
   logic [ADDR_W-1:0]   req_addr;
   logic                dec_hit;
   logic [SW-1:0]       dec_idx;
   int                  rr_idx;

   // Scan downward so the requester closest to the pointer wins.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      rr_idx    = 0;
      for (int k = NM - 1; k >= 0; k--) begin
         rr_idx = int'(ptr_q) + k;
         if (rr_idx >= NM) rr_idx = rr_idx - NM;
         if (m_valid[MW'(rr_idx)]) begin
            req_found = 1'b1;
            req_idx   = MW'(rr_idx);
         end
      end
   end

   // Lowest-numbered matching slave wins on overlapping windows.
   always_comb begin
      req_addr = m_addr[int'(req_idx)*ADDR_W +: ADDR_W];
      dec_hit  = 1'b0;
      dec_idx  = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if ((req_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            dec_hit = 1'b1;
            dec_idx = SW'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gidx_d      = gidx_q;
      slv_d       = slv_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      s_cs_d      = s_cs_q;
      s_we_d      = s_we_q;
      s_addr_d    = s_addr_q;
      s_wdata_d   = s_wdata_q;
      m_ready_d   = '0;
      m_err_d     = '0;
      m_rdata_d   = '0;
      err_count_d = err_count_q;
      case (state_q)
         ST_IDLE: begin
            if (req_found) begin
               grant_d          = '0;
               grant_d[req_idx] = 1'b1;
               gidx_d           = req_idx;
               if (dec_hit) begin
                  state_d          = ST_ACCESS;
                  slv_d            = dec_idx;
                  cnt_d            = '0;
                  s_cs_d           = '0;
                  s_cs_d[dec_idx]  = 1'b1;
                  s_we_d           = m_we[req_idx];
                  s_addr_d         = req_addr & ~SLV_MASK[int'(dec_idx)*ADDR_W +: ADDR_W];
                  s_wdata_d        = m_wdata[int'(req_idx)*DATA_W +: DATA_W];
               end else begin
                  state_d            = ST_RESP;
                  m_ready_d[req_idx] = 1'b1;
                  m_err_d[req_idx]   = 1'b1;
                  m_rdata_d[int'(req_idx)*DATA_W +: DATA_W] = ERR_RDATA;
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
               end
            end
         end
         ST_ACCESS: begin
            if (s_ready[slv_q]) begin
               state_d           = ST_RESP;
               s_cs_d            = '0;
               s_we_d            = 1'b0;
               m_ready_d[gidx_q] = 1'b1;
               m_rdata_d[int'(gidx_q)*DATA_W +: DATA_W] = s_rdata[int'(slv_q)*DATA_W +: DATA_W];
            end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
               state_d           = ST_RESP;
               s_cs_d            = '0;
               s_we_d            = 1'b0;
               m_ready_d[gidx_q] = 1'b1;
               m_err_d[gidx_q]   = 1'b1;
               m_rdata_d[int'(gidx_q)*DATA_W +: DATA_W] = ERR_RDATA;
               if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = (gidx_q == MW'(NM - 1)) ? '0 : gidx_q + MW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         gidx_q      <= '0;
         slv_q       <= '0;
         cnt_q       <= '0;
         grant_q     <= '0;
         s_cs_q      <= '0;
         s_we_q      <= 1'b0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
         m_ready_q   <= '0;
         m_err_q     <= '0;
         m_rdata_q   <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gidx_q      <= gidx_d;
         slv_q       <= slv_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         s_cs_q      <= s_cs_d;
         s_we_q      <= s_we_d;
         s_addr_q    <= s_addr_d;
         s_wdata_q   <= s_wdata_d;
         m_ready_q   <= m_ready_d;
         m_err_q     <= m_err_d;
         m_rdata_q   <= m_rdata_d;
         err_count_q <= err_count_d;
      end
   end

   assign grant     = grant_q;
   assign s_cs      = s_cs_q;
   assign s_we      = s_we_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign m_ready   = m_ready_q;
   assign m_err     = m_err_q;
   assign m_rdata   = m_rdata_q;
   assign err_count = err_count_q;

endmodule

// File: doc/soc_interconnect.md
# soc_interconnect

Parametrised successor to the single-master SoC bus: connects NM bus masters (CPU, plus a future DMA engine) to NS memory-mapped slaves (RAM, UART, timer, spare) through one shared, non-pipelined transfer path. It provides:
- round-robin arbitration between masters;
- mask/base address decode, with the local offset passed to each slave;
- a per-transfer slave ready handshake with timeout;
- an error response with a saturating error counter.

It sits between the masters and peripherals in the SoC top level.

## Interface
Parameters:
- NM, 2, number of masters (1..4)
- NS, 4, number of slaves (1..8)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- SLV_BASE, {8'hA0,8'h90,8'h80,8'h00}, packed NS*ADDR_W base addresses, slave 0 in LSBs
- SLV_MASK, {8'hF0,8'hF0,8'hF0,8'h80}, packed NS*ADDR_W decode masks, slave 0 in LSBs
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout
- ERR_RDATA, all ones, read data returned on an error

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- m_valid  in  NM  request per master, held until its m_ready
- m_we  in  NM  1 = write
- m_addr  in  NM*ADDR_W  packed, master 0 in LSBs
- m_wdata  in  NM*DATA_W  packed write data
- m_rdata  out  NM*DATA_W  packed read data, valid with m_ready
- m_ready  out  NM  one-cycle completion pulse
- m_err  out  NM  error flag, valid with m_ready
- s_cs  out  NS  slave select, one-hot or zero
- s_we  out  1  shared write enable, qualified by s_cs
- s_addr  out  ADDR_W  local offset, addr & ~SLV_MASK[i]
- s_wdata  out  DATA_W  shared write data
- s_rdata  in  NS*DATA_W  packed slave read data
- s_ready  in  NS  slave completion, sampled only while that slave's s_cs is high
- grant  out  NM  one-hot owner of the current transfer, 0 when idle
- err_count  out  8  saturating count of error responses

## Operation
- States: IDLE, ACCESS, RESP. Exactly one transfer is in flight.
- IDLE:
  - If any m_valid is set, grant the first requesting master at or after the round-robin pointer.
  - Latch that master's we, addr and wdata.
  - Decode the latched address: slave i matches when (addr & SLV_MASK[i]) == SLV_BASE[i]. If several match, the lowest i wins.
  - Mapped address: go to ACCESS. Unmapped address: go to RESP with error.
- ACCESS:
  - Drive s_cs[i]=1 with s_we, s_addr and s_wdata from the latched request.
  - When s_ready[i]=1: capture s_rdata[i] (reads), go to RESP, err=0.
  - When TIMEOUT!=0 and the ACCESS cycle count reaches TIMEOUT without s_ready: deassert cs, go to RESP, err=1.
  - s_ready on cycle TIMEOUT counts as success.
- RESP (one cycle):
  - m_ready[g]=1 and m_err[g]=err for the granted master g.
  - m_rdata slice g carries the captured data, or ERR_RDATA on error.
  - On writes, rdata is don't-care.
  - Pointer becomes (g+1) mod NM; return to IDLE.
- err_count increments once per error response and saturates at 255.
- Inputs from masters are ignored while a transfer is in flight. Non-granted masters keep m_valid high and wait.
- A master must not change its request between m_valid rise and m_ready.

## Timing
- Reset (async assert, sync release): state IDLE, pointer 0, grant=0, s_cs=0, s_we=0, s_addr=0, s_wdata=0, m_ready=0, m_err=0, m_rdata=0, err_count=0.
- Reset mid-transfer aborts immediately; no m_ready is issued for the aborted transfer.
- Mapped transfer with zero-wait slave:
  - m_valid sampled at edge 0; s_cs high in cycle 1.
  - s_ready in cycle 1 gives m_ready in cycle 2 (3-cycle latency).
  - Each slave wait cycle adds 1.
- Unmapped transfer: m_ready with m_err in the cycle after grant (2-cycle latency); no s_cs pulse.
- Timeout: s_cs is high for exactly TIMEOUT cycles, then RESP.
- Back-to-back: after RESP the next grant occurs in the following IDLE cycle, giving a minimum of 3 cycles per transfer.
- grant is high from the ACCESS or RESP entry through RESP, inclusive.
- Simultaneous requests are arbitrated in the same IDLE cycle by the pointer.

## Test plan
- Master 0 writes 0x5A to 0x12, then reads 0x12 from the RAM model (1-wait ready): s_cs[0] is asserted with s_addr=0x12. The read returns m_rdata=0x5A, m_err=0, latency 4.
- Master 0 reads 0x85 from the UART model: s_cs[1] is asserted with s_addr=0x05. The read returns the model data, and no other s_cs bit rises.
- Master 1 reads 0xF0 (unmapped): m_ready after 2 cycles with m_err=1 and rdata=0xFF. err_count=1, and s_cs stays 0.
- Slave 2 never asserts ready, TIMEOUT=16: s_cs[2] is high for exactly 16 cycles, then m_err=1 and rdata=0xFF. A following access to slave 0 succeeds.
- Both masters hold m_valid for 4 transfers: grants alternate 0,1,0,1 starting with master 0 after reset. Neither master starves.
- rst_n asserted during ACCESS: all outputs reach their reset values immediately and no m_ready is issued. After release, the first request from master 1 is granted only if m_valid[0]=0.
